// File: rtl/cr_had_ddc_burst.sv
// HAD direct-download burst controller: injects RV32 instructions into the HAD IR to move
// scan-register data to/from memory. Optional macro CR_HAD_DDC_TIMEOUT_EN enables a retire watchdog.
module cr_had_ddc_burst #(
    parameter int CNT_WIDTH     = 16,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                 cpuclk,
    input  logic                 hadrst_b,
    input  logic                 regs_xx_ddc_en,
    input  logic                 regs_ddc_mode,
    input  logic [1:0]           regs_ddc_size,
    input  logic [CNT_WIDTH-1:0] regs_ddc_cnt,
    input  logic                 jtag_xx_update_dr,
    input  logic                 regs_ddc_daddr_sel,
    input  logic                 regs_ddc_ddata_sel,
    input  logic                 iu_had_xx_retire,
    input  logic                 iu_had_xx_expt,
    output logic                 ddc_regs_update_ir,
    output logic [31:0]          ddc_regs_ir,
    output logic                 ddc_regs_update_csr,
    output logic                 ddc_regs_ffy,
    output logic                 ddc_regs_capture_data,
    output logic                 ddc_regs_busy,
    output logic                 ddc_regs_done,
    output logic                 ddc_regs_err,
    output logic [CNT_WIDTH-1:0] ddc_regs_remain
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR_WAIT,
        ADDR_LD,
        ADDR_RET,
        DATA_WAIT,
        DATA_LD,
        DATA_RET,
        MEM_LD,
        MEM_RET,
        UP_WAIT,
        ADDR_GEN,
        GEN_RET,
        DONE,
        ERR
    } state_t;

    localparam logic [31:0] IR_MV_X1   = 32'h0000_8093;
    localparam logic [31:0] IR_MV_X2   = 32'h0001_0113;
    localparam logic [31:0] IR_SB      = 32'h0020_8023;
    localparam logic [31:0] IR_SH      = 32'h0020_9023;
    localparam logic [31:0] IR_SW      = 32'h0020_A023;
    localparam logic [31:0] IR_LBU     = 32'h0000_C103;
    localparam logic [31:0] IR_LHU     = 32'h0000_D103;
    localparam logic [31:0] IR_LW      = 32'h0000_A103;
    localparam logic [31:0] IR_ADDI_1  = 32'h0010_8093;
    localparam logic [31:0] IR_ADDI_2  = 32'h0020_8093;
    localparam logic [31:0] IR_ADDI_4  = 32'h0040_8093;

    state_t               state_q;
    state_t               state_nxt;
    logic                 mode_q;
    logic [1:0]           size_q;
    logic [CNT_WIDTH-1:0] remain_q;
    logic                 unlimited_q;
    logic                 addr_ready;
    logic                 data_ready;
    logic                 in_ret;
    logic                 in_ld;
    logic                 last_beat;

    assign addr_ready = jtag_xx_update_dr & regs_ddc_daddr_sel;
    assign data_ready = jtag_xx_update_dr & regs_ddc_ddata_sel;
    assign in_ret     = (state_q == ADDR_RET) || (state_q == DATA_RET) ||
                        (state_q == MEM_RET)  || (state_q == GEN_RET);
    assign in_ld      = (state_q == ADDR_LD)  || (state_q == DATA_LD) ||
                        (state_q == MEM_LD)   || (state_q == ADDR_GEN);
    assign last_beat  = !unlimited_q && (remain_q == CNT_WIDTH'(1));

`ifdef CR_HAD_DDC_TIMEOUT_EN
    localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

    logic [TIMEOUT_WIDTH-1:0] to_cnt_q;
    logic                     timeout_hit;

    // Watchdog restarts on every injected instruction and counts idle cycles while waiting for retire
    always_ff @(posedge cpuclk or negedge hadrst_b) begin
        if (!hadrst_b) begin
            to_cnt_q <= '0;
        end else if (in_ld) begin
            to_cnt_q <= '0;
        end else if (in_ret && !iu_had_xx_retire) begin
            to_cnt_q <= to_cnt_q + TIMEOUT_WIDTH'(1);
        end
    end

    assign timeout_hit = in_ret && !iu_had_xx_retire && (to_cnt_q == TO_LAST);
`else
    logic timeout_hit;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge cpuclk or negedge hadrst_b) begin
        if (!hadrst_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:      if (regs_xx_ddc_en) state_nxt = ADDR_WAIT;
            ADDR_WAIT: begin
                if (addr_ready && (regs_ddc_size == 2'b11)) state_nxt = ERR;
                else if (addr_ready)                         state_nxt = ADDR_LD;
                else if (!regs_xx_ddc_en)                    state_nxt = IDLE;
            end
            ADDR_LD:   state_nxt = ADDR_RET;
            ADDR_RET:  if (iu_had_xx_retire) state_nxt = mode_q ? MEM_LD : DATA_WAIT;
            DATA_WAIT: begin
                if (data_ready)           state_nxt = DATA_LD;
                else if (addr_ready)      state_nxt = ADDR_LD;
                else if (!regs_xx_ddc_en) state_nxt = IDLE;
            end
            DATA_LD:   state_nxt = DATA_RET;
            DATA_RET:  if (iu_had_xx_retire) state_nxt = MEM_LD;
            MEM_LD:    state_nxt = MEM_RET;
            MEM_RET:   if (iu_had_xx_retire) state_nxt = mode_q ? UP_WAIT : ADDR_GEN;
            UP_WAIT: begin
                if (data_ready)           state_nxt = ADDR_GEN;
                else if (!regs_xx_ddc_en) state_nxt = IDLE;
            end
            ADDR_GEN:  state_nxt = GEN_RET;
            GEN_RET: begin
                if (iu_had_xx_retire) begin
                    if (last_beat)   state_nxt = DONE;
                    else if (mode_q) state_nxt = MEM_LD;
                    else             state_nxt = DATA_WAIT;
                end
            end
            DONE: begin
                if (addr_ready)           state_nxt = ADDR_LD;
                else if (!regs_xx_ddc_en) state_nxt = IDLE;
            end
            ERR:       if (!regs_xx_ddc_en) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        // An exception or watchdog expiry overrides any retire seen in the same cycle
        if (in_ret && (iu_had_xx_expt || timeout_hit)) state_nxt = ERR;
    end

    // Transfer parameters are captured once per address load so a rebase can change them
    always_ff @(posedge cpuclk or negedge hadrst_b) begin
        if (!hadrst_b) begin
            mode_q      <= 1'b0;
            size_q      <= 2'b00;
            remain_q    <= '0;
            unlimited_q <= 1'b0;
        end else if (state_q == ADDR_LD) begin
            mode_q      <= regs_ddc_mode;
            size_q      <= regs_ddc_size;
            remain_q    <= regs_ddc_cnt;
            unlimited_q <= (regs_ddc_cnt == '0);
        end else if ((state_q == GEN_RET) && iu_had_xx_retire && !iu_had_xx_expt &&
                     !unlimited_q && (remain_q != '0)) begin
            remain_q    <= remain_q - CNT_WIDTH'(1);
        end
    end

    always_comb begin
        ddc_regs_ir = 32'h0;
        case (state_q)
            ADDR_LD: ddc_regs_ir = IR_MV_X1;
            DATA_LD: ddc_regs_ir = IR_MV_X2;
            MEM_LD: begin
                case ({mode_q, size_q})
                    3'b000:  ddc_regs_ir = IR_SB;
                    3'b001:  ddc_regs_ir = IR_SH;
                    3'b100:  ddc_regs_ir = IR_LBU;
                    3'b101:  ddc_regs_ir = IR_LHU;
                    3'b110,
                    3'b111:  ddc_regs_ir = IR_LW;
                    default: ddc_regs_ir = IR_SW;
                endcase
            end
            ADDR_GEN: begin
                case (size_q)
                    2'b00:   ddc_regs_ir = IR_ADDI_1;
                    2'b01:   ddc_regs_ir = IR_ADDI_2;
                    default: ddc_regs_ir = IR_ADDI_4;
                endcase
            end
            default: ddc_regs_ir = 32'h0;
        endcase
    end

    assign ddc_regs_update_ir    = in_ld;
    assign ddc_regs_update_csr   = in_ld;
    assign ddc_regs_ffy          = (state_q == ADDR_LD) || (state_q == DATA_LD);
    assign ddc_regs_capture_data = (state_q == MEM_RET) && mode_q &&
                                   iu_had_xx_retire && !iu_had_xx_expt && !timeout_hit;
    assign ddc_regs_busy         = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);
    assign ddc_regs_done         = (state_q == DONE);
    assign ddc_regs_err          = (state_q == ERR);
    assign ddc_regs_remain       = remain_q;

endmodule

// File: tb/tb_cr_had_ddc_burst.sv
// Directed self-checking bench for cr_had_ddc_burst; runs with a 4-bit watchdog and
// expects timeout behaviour to follow CR_HAD_DDC_TIMEOUT_EN.
module tb_cr_had_ddc_burst;

    localparam int CW = 16;
    localparam int TW = 4;

    logic          cpuclk;
    logic          hadrst_b;
    logic          regs_xx_ddc_en;
    logic          regs_ddc_mode;
    logic [1:0]    regs_ddc_size;
    logic [CW-1:0] regs_ddc_cnt;
    logic          jtag_xx_update_dr;
    logic          regs_ddc_daddr_sel;
    logic          regs_ddc_ddata_sel;
    logic          iu_had_xx_retire;
    logic          iu_had_xx_expt;
    logic          ddc_regs_update_ir;
    logic [31:0]   ddc_regs_ir;
    logic          ddc_regs_update_csr;
    logic          ddc_regs_ffy;
    logic          ddc_regs_capture_data;
    logic          ddc_regs_busy;
    logic          ddc_regs_done;
    logic          ddc_regs_err;
    logic [CW-1:0] ddc_regs_remain;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ir_log[$];
    logic [31:0] exp_dl[7] = '{32'h00008093, 32'h00010113, 32'h0020A023, 32'h00408093,
                               32'h00010113, 32'h0020A023, 32'h00408093};

    cr_had_ddc_burst #(.CNT_WIDTH(CW), .TIMEOUT_WIDTH(TW)) dut (
        .cpuclk                (cpuclk),
        .hadrst_b              (hadrst_b),
        .regs_xx_ddc_en        (regs_xx_ddc_en),
        .regs_ddc_mode         (regs_ddc_mode),
        .regs_ddc_size         (regs_ddc_size),
        .regs_ddc_cnt          (regs_ddc_cnt),
        .jtag_xx_update_dr     (jtag_xx_update_dr),
        .regs_ddc_daddr_sel    (regs_ddc_daddr_sel),
        .regs_ddc_ddata_sel    (regs_ddc_ddata_sel),
        .iu_had_xx_retire      (iu_had_xx_retire),
        .iu_had_xx_expt        (iu_had_xx_expt),
        .ddc_regs_update_ir    (ddc_regs_update_ir),
        .ddc_regs_ir           (ddc_regs_ir),
        .ddc_regs_update_csr   (ddc_regs_update_csr),
        .ddc_regs_ffy          (ddc_regs_ffy),
        .ddc_regs_capture_data (ddc_regs_capture_data),
        .ddc_regs_busy         (ddc_regs_busy),
        .ddc_regs_done         (ddc_regs_done),
        .ddc_regs_err          (ddc_regs_err),
        .ddc_regs_remain       (ddc_regs_remain)
    );

    initial cpuclk = 1'b0;
    always #5 cpuclk = ~cpuclk;

    // Record every injected instruction mid-cycle, away from the clock edge
    always @(negedge cpuclk) begin
        if (hadrst_b && ddc_regs_update_ir) ir_log.push_back(ddc_regs_ir);
    end

    task automatic tick();
        @(posedge cpuclk);
        #1;
    endtask

    task automatic clear_inputs();
        regs_xx_ddc_en     = 1'b0;
        regs_ddc_mode      = 1'b0;
        regs_ddc_size      = 2'b00;
        regs_ddc_cnt       = '0;
        jtag_xx_update_dr  = 1'b0;
        regs_ddc_daddr_sel = 1'b0;
        regs_ddc_ddata_sel = 1'b0;
        iu_had_xx_retire   = 1'b0;
        iu_had_xx_expt     = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        hadrst_b = 1'b0;
        repeat (2) tick();
        hadrst_b = 1'b1;
        #1;
        ir_log.delete();
    endtask

    task automatic start(input logic mode, input logic [1:0] size, input logic [CW-1:0] cnt);
        do_reset();
        regs_ddc_mode  = mode;
        regs_ddc_size  = size;
        regs_ddc_cnt   = cnt;
        regs_xx_ddc_en = 1'b1;
        tick();
    endtask

    task automatic scan_addr();
        jtag_xx_update_dr  = 1'b1;
        regs_ddc_daddr_sel = 1'b1;
        tick();
        jtag_xx_update_dr  = 1'b0;
        regs_ddc_daddr_sel = 1'b0;
        #1;
    endtask

    task automatic scan_data();
        jtag_xx_update_dr  = 1'b1;
        regs_ddc_ddata_sel = 1'b1;
        tick();
        jtag_xx_update_dr  = 1'b0;
        regs_ddc_ddata_sel = 1'b0;
        #1;
    endtask

    task automatic retire_one();
        iu_had_xx_retire = 1'b1;
        tick();
        iu_had_xx_retire = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        hadrst_b           = 1'b0;
        regs_xx_ddc_en     = 1'b1;
        jtag_xx_update_dr  = 1'b1;
        regs_ddc_daddr_sel = 1'b1;
        regs_ddc_cnt       = 16'd7;
        repeat (2) tick();
        checks++;
        if ({ddc_regs_update_ir, ddc_regs_update_csr, ddc_regs_ffy, ddc_regs_capture_data,
             ddc_regs_busy, ddc_regs_done, ddc_regs_err} !== 7'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b exp=0000000", {ddc_regs_update_ir,
                     ddc_regs_update_csr, ddc_regs_ffy, ddc_regs_capture_data,
                     ddc_regs_busy, ddc_regs_done, ddc_regs_err});
        end
        checks++;
        if (ddc_regs_ir !== 32'h0 || ddc_regs_remain !== '0) begin
            failures++;
            $display("[TB] FAIL reset_ir_remain got ir=%h remain=%0d exp ir=0 remain=0",
                     ddc_regs_ir, ddc_regs_remain);
        end
        clear_inputs();
        hadrst_b = 1'b1;
        tick();
        checks++;
        if (ddc_regs_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_idle_busy got=%b exp=0", ddc_regs_busy);
        end
    endtask

    task automatic test_download_word();
        start(1'b0, 2'b10, 16'd2);
        scan_addr();
        checks++;
        if (ddc_regs_update_ir !== 1'b1 || ddc_regs_update_csr !== 1'b1 || ddc_regs_ffy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL dl_addr_ld got upd=%b csr=%b ffy=%b exp 1 1 1",
                     ddc_regs_update_ir, ddc_regs_update_csr, ddc_regs_ffy);
        end
        tick();
        checks++;
        if (ddc_regs_update_ir !== 1'b0 || ddc_regs_busy !== 1'b1 || ddc_regs_ir !== 32'h0) begin
            failures++;
            $display("[TB] FAIL dl_addr_ret got upd=%b busy=%b ir=%h exp 0 1 0",
                     ddc_regs_update_ir, ddc_regs_busy, ddc_regs_ir);
        end
        retire_one();
        for (int beat = 0; beat < 2; beat++) begin
            scan_data();
            tick();
            retire_one();
            checks++;
            if (ddc_regs_ffy !== 1'b0 || ddc_regs_update_csr !== 1'b1) begin
                failures++;
                $display("[TB] FAIL dl_mem_ld_ffy beat=%0d got ffy=%b csr=%b exp 0 1",
                         beat, ddc_regs_ffy, ddc_regs_update_csr);
            end
            tick();
            retire_one();
            tick();
            retire_one();
            if (beat == 0) begin
                checks++;
                if (ddc_regs_remain !== 16'd1 || ddc_regs_done !== 1'b0 || ddc_regs_busy !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL dl_mid got remain=%0d done=%b busy=%b exp 1 0 1",
                             ddc_regs_remain, ddc_regs_done, ddc_regs_busy);
                end
            end
        end
        checks++;
        if (ddc_regs_done !== 1'b1 || ddc_regs_remain !== '0 || ddc_regs_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL dl_done got done=%b remain=%0d busy=%b exp 1 0 0",
                     ddc_regs_done, ddc_regs_remain, ddc_regs_busy);
        end
        checks++;
        if (ir_log.size() != 7) begin
            failures++;
            $display("[TB] FAIL dl_ir_count got=%0d exp=7", ir_log.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (ir_log[i] !== exp_dl[i]) begin
                    failures++;
                    $display("[TB] FAIL dl_ir[%0d] got=%h exp=%h", i, ir_log[i], exp_dl[i]);
                end
            end
        end
        regs_xx_ddc_en = 1'b0;
        tick();
        checks++;
        if (ddc_regs_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL dl_done_clear got=%b exp=0", ddc_regs_done);
        end
    endtask

    task automatic test_upload_byte();
        start(1'b1, 2'b00, 16'd1);
        scan_addr();
        tick();
        retire_one();
        checks++;
        if (ddc_regs_update_ir !== 1'b1 || ddc_regs_ir !== 32'h0000C103) begin
            failures++;
            $display("[TB] FAIL ul_mem_ld got upd=%b ir=%h exp 1 0000c103",
                     ddc_regs_update_ir, ddc_regs_ir);
        end
        tick();
        checks++;
        if (ddc_regs_capture_data !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ul_capture_early got=%b exp=0", ddc_regs_capture_data);
        end
        iu_had_xx_retire = 1'b1;
        #1;
        checks++;
        if (ddc_regs_capture_data !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ul_capture got=%b exp=1", ddc_regs_capture_data);
        end
        tick();
        iu_had_xx_retire = 1'b0;
        #1;
        checks++;
        if (ddc_regs_capture_data !== 1'b0 || ddc_regs_busy !== 1'b1 || ddc_regs_update_ir !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ul_up_wait got cap=%b busy=%b upd=%b exp 0 1 0",
                     ddc_regs_capture_data, ddc_regs_busy, ddc_regs_update_ir);
        end
        scan_data();
        checks++;
        if (ddc_regs_update_ir !== 1'b1 || ddc_regs_ir !== 32'h00108093 || ddc_regs_ffy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ul_addr_gen got upd=%b ir=%h ffy=%b exp 1 00108093 0",
                     ddc_regs_update_ir, ddc_regs_ir, ddc_regs_ffy);
        end
        tick();
        retire_one();
        checks++;
        if (ddc_regs_done !== 1'b1 || ddc_regs_remain !== '0) begin
            failures++;
            $display("[TB] FAIL ul_done got done=%b remain=%0d exp 1 0",
                     ddc_regs_done, ddc_regs_remain);
        end
    endtask

    task automatic test_illegal_size();
        start(1'b0, 2'b11, 16'd1);
        scan_addr();
        checks++;
        if (ddc_regs_err !== 1'b1 || ddc_regs_update_ir !== 1'b0 || ddc_regs_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ill_err got err=%b upd=%b busy=%b exp 1 0 0",
                     ddc_regs_err, ddc_regs_update_ir, ddc_regs_busy);
        end
        tick();
        checks++;
        if (ddc_regs_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ill_sticky got=%b exp=1", ddc_regs_err);
        end
        regs_xx_ddc_en = 1'b0;
        tick();
        checks++;
        if (ddc_regs_err !== 1'b0 || ddc_regs_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ill_idle got err=%b busy=%b exp 0 0", ddc_regs_err, ddc_regs_busy);
        end
    endtask

    task automatic test_expt();
        start(1'b0, 2'b01, 16'd1);
        scan_addr();
        tick();
        retire_one();
        iu_had_xx_expt = 1'b1;
        tick();
        iu_had_xx_expt = 1'b0;
        #1;
        checks++;
        if (ddc_regs_err !== 1'b0 || ddc_regs_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL expt_ignored got err=%b busy=%b exp 0 1", ddc_regs_err, ddc_regs_busy);
        end
        scan_data();
        tick();
        retire_one();
        checks++;
        if (ddc_regs_ir !== 32'h00209023) begin
            failures++;
            $display("[TB] FAIL expt_sh got=%h exp=00209023", ddc_regs_ir);
        end
        tick();
        iu_had_xx_retire = 1'b1;
        iu_had_xx_expt   = 1'b1;
        tick();
        iu_had_xx_retire = 1'b0;
        iu_had_xx_expt   = 1'b0;
        #1;
        checks++;
        if (ddc_regs_err !== 1'b1 || ddc_regs_busy !== 1'b0 || ddc_regs_update_ir !== 1'b0) begin
            failures++;
            $display("[TB] FAIL expt_err got err=%b busy=%b upd=%b exp 1 0 0",
                     ddc_regs_err, ddc_regs_busy, ddc_regs_update_ir);
        end
    endtask

    task automatic test_unlimited();
        start(1'b0, 2'b10, 16'd0);
        scan_addr();
        tick();
        retire_one();
        for (int beat = 0; beat < 5; beat++) begin
            scan_data();
            tick();
            retire_one();
            tick();
            retire_one();
            tick();
            retire_one();
            checks++;
            if (ddc_regs_remain !== '0 || ddc_regs_done !== 1'b0 || ddc_regs_busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL unl_beat%0d got remain=%0d done=%b busy=%b exp 0 0 1",
                         beat, ddc_regs_remain, ddc_regs_done, ddc_regs_busy);
            end
        end
        regs_ddc_cnt = 16'd3;
        scan_addr();
        checks++;
        if (ddc_regs_update_ir !== 1'b1 || ddc_regs_ir !== 32'h00008093) begin
            failures++;
            $display("[TB] FAIL unl_rebase got upd=%b ir=%h exp 1 00008093",
                     ddc_regs_update_ir, ddc_regs_ir);
        end
        regs_xx_ddc_en = 1'b0;
        tick();
        checks++;
        if (ddc_regs_remain !== 16'd3 || ddc_regs_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL unl_reload got remain=%0d busy=%b exp 3 1",
                     ddc_regs_remain, ddc_regs_busy);
        end
        retire_one();
        tick();
        checks++;
        if (ddc_regs_busy !== 1'b0 || ddc_regs_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL unl_en_drop got busy=%b err=%b exp 0 0", ddc_regs_busy, ddc_regs_err);
        end
    endtask

    task automatic test_timeout();
        start(1'b0, 2'b10, 16'd1);
        scan_addr();
        tick();
        retire_one();
        scan_data();
        tick();
        repeat (14) tick();
        checks++;
        if (ddc_regs_busy !== 1'b1 || ddc_regs_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL to_cycle15 got busy=%b err=%b exp 1 0", ddc_regs_busy, ddc_regs_err);
        end
`ifdef CR_HAD_DDC_TIMEOUT_EN
        tick();
        checks++;
        if (ddc_regs_err !== 1'b1 || ddc_regs_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL to_err got err=%b busy=%b exp 1 0", ddc_regs_err, ddc_regs_busy);
        end
`else
        repeat (85) tick();
        checks++;
        if (ddc_regs_busy !== 1'b1 || ddc_regs_err !== 1'b0 || ddc_regs_update_ir !== 1'b0) begin
            failures++;
            $display("[TB] FAIL to_wait got busy=%b err=%b upd=%b exp 1 0 0",
                     ddc_regs_busy, ddc_regs_err, ddc_regs_update_ir);
        end
        retire_one();
        checks++;
        if (ddc_regs_ir !== 32'h0020A023) begin
            failures++;
            $display("[TB] FAIL to_resume got=%h exp=0020a023", ddc_regs_ir);
        end
`endif
    endtask

    initial begin
        clear_inputs();
        hadrst_b = 1'b0;
        test_reset();
        test_download_word();
        test_upload_byte();
        test_illegal_size();
        test_expt();
        test_unlimited();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
